// File: rtl/rf_wr_sched.sv
// Round-robin scheduler sharing the SIMD register file's single write port among N_REQ requesters, plus a per-entry valid scoreboard.
// Latency: one cycle from an accepted request to rf_wen; the scoreboard bit sets on the edge that ends the rf_wen cycle.
// Backpressure: req_ready is one-hot at the round-robin winner, all-zero under hold or reset; out-of-range writes are accepted and flagged.
module rf_wr_sched #(
    parameter int N_REQ        = 3,
    parameter int phit_size    = 512,
    parameter int SIMD_degree  = 16,
    parameter int dwidth_RFadd = 4,
    parameter int depth_RF     = 16,
    parameter int CNT_W        = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ*dwidth_RFadd-1:0]     req_addr,
    input  logic [N_REQ*phit_size-1:0]        req_data,
    input  logic [N_REQ*SIMD_degree-1:0]      req_tlast,
    input  logic                              hold,
    input  logic                              clr_en,
    input  logic [dwidth_RFadd-1:0]           clr_addr,
    input  logic                              flush,
    output logic                              rf_wen,
    output logic [dwidth_RFadd-1:0]           rf_wr_addr,
    output logic [phit_size-1:0]              rf_d_in,
    output logic [SIMD_degree-1:0]            rf_tlast_in,
    output logic [depth_RF-1:0]               rf_valid,
    output logic                              err_oob,
    output logic [CNT_W-1:0]                  wr_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    gnt_any;
    logic [PTR_W-1:0]        gnt_idx;
    logic [N_REQ-1:0]        gnt_oh;
    logic [dwidth_RFadd-1:0] sel_addr;
    logic [phit_size-1:0]    sel_data;
    logic [SIMD_degree-1:0]  sel_tlast;
    logic                    sel_in_range;
    logic                    xfer;

    logic                    wen_q, wen_d;
    logic                    err_q, err_d;
    logic [dwidth_RFadd-1:0] addr_q, addr_d;
    logic [phit_size-1:0]    data_q, data_d;
    logic [SIMD_degree-1:0]  tlast_q, tlast_d;
    logic [depth_RF-1:0]     valid_q, valid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Round-robin search: first valid at or above rr_ptr, else wrap to the lowest valid below it.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[i] && (i >= int'(rr_ptr_q))) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(i);
            end
        end
        // Hold and reset suppress new grants; a registered write already in flight is unaffected.
        if (hold || !rst_n) begin
            gnt_any = 1'b0;
        end
        gnt_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_oh[i] = gnt_any && (gnt_idx == PTR_W'(i));
        end
    end

    assign req_ready = gnt_oh;
    assign xfer      = gnt_any;

    // Select the winner's address, data and tlast slices.
    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        sel_tlast = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                sel_addr  = req_addr[i*dwidth_RFadd +: dwidth_RFadd];
                sel_data  = req_data[i*phit_size +: phit_size];
                sel_tlast = req_tlast[i*SIMD_degree +: SIMD_degree];
            end
        end
        sel_in_range = (int'(sel_addr) < depth_RF);
    end

    // Next-state for pointer, write register, error pulse, scoreboard and counter.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end

        // Out-of-range writes complete the handshake but never reach the register file.
        wen_d   = xfer && sel_in_range;
        err_d   = xfer && !sel_in_range;
        addr_d  = addr_q;
        data_d  = data_q;
        tlast_d = tlast_q;
        if (xfer && sel_in_range) begin
            addr_d  = sel_addr;
            data_d  = sel_data;
            tlast_d = sel_tlast;
        end

        // Per-bit priority: write-set beats single clear beats flush.
        valid_d = valid_q;
        for (int k = 0; k < depth_RF; k++) begin
            if (wen_q && (addr_q == dwidth_RFadd'(k))) begin
                valid_d[k] = 1'b1;
            end else if (clr_en && (clr_addr == dwidth_RFadd'(k))) begin
                valid_d[k] = 1'b0;
            end else if (flush) begin
                valid_d[k] = 1'b0;
            end
        end

        cnt_d = cnt_q;
        if (wen_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards any pending write so nothing is re-issued afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            tlast_q  <= '0;
            valid_q  <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            tlast_q  <= tlast_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rf_wen      = wen_q;
    assign rf_wr_addr  = addr_q;
    assign rf_d_in     = data_q;
    assign rf_tlast_in = tlast_q;
    assign rf_valid    = valid_q;
    assign err_oob     = err_q;
    assign wr_count    = cnt_q;

endmodule

// File: tb/tb_rf_wr_sched.sv
// Directed bench for rf_wr_sched with a negedge monitor holding a reference model and a write scoreboard queue.
// Stimulus changes 1 ns after posedge; the monitor compares at negedge, directed checks sample 1-2 ns after posedge.
// Summary line reports comparisons made and comparisons failed.
module tb_rf_wr_sched;

    localparam int N  = 3;
    localparam int PW = 512;
    localparam int TW = 16;
    localparam int AW = 4;
    localparam int D  = 12;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*PW-1:0]   req_data = '0;
    logic [N*TW-1:0]   req_tlast = '0;
    logic              hold = 1'b0;
    logic              clr_en = 1'b0;
    logic [AW-1:0]     clr_addr = '0;
    logic              flush = 1'b0;
    logic              rf_wen;
    logic [AW-1:0]     rf_wr_addr;
    logic [PW-1:0]     rf_d_in;
    logic [TW-1:0]     rf_tlast_in;
    logic [D-1:0]      rf_valid;
    logic              err_oob;
    logic [CW-1:0]     wr_count;

    rf_wr_sched #(
        .N_REQ(N), .phit_size(PW), .SIMD_degree(TW),
        .dwidth_RFadd(AW), .depth_RF(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_tlast(req_tlast),
        .hold(hold), .clr_en(clr_en), .clr_addr(clr_addr), .flush(flush),
        .rf_wen(rf_wen), .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
        .rf_tlast_in(rf_tlast_in), .rf_valid(rf_valid), .err_oob(err_oob),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             oob;
        logic [AW-1:0]  addr;
        logic [PW-1:0]  data;
        logic [TW-1:0]  tlast;
    } wr_t;

    wr_t  exp_q[$];
    int   gl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int           m_ptr = 0;
    logic [D-1:0] m_valid = '0;
    int           m_cnt = 0;
    wr_t          m_w;
    bit           e_wen;
    bit           e_oob;
    int           g;
    int           mi;
    logic [N-1:0] e_rdy;
    logic [D-1:0] nv;

    // Monitor: pop the write expected this cycle, check outputs, advance the model, check the grant.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ptr   = 0;
            m_valid = '0;
            m_cnt   = 0;
            chk("rst_ready", req_ready, '0);
            chk("rst_wen", rf_wen, '0);
            chk("rst_valid", rf_valid, '0);
        end else begin
            e_wen = 1'b0;
            e_oob = 1'b0;
            if (exp_q.size() > 0) begin
                m_w   = exp_q.pop_front();
                e_wen = !m_w.oob;
                e_oob = m_w.oob;
            end
            chk("mon_wen", rf_wen, e_wen);
            chk("mon_err", err_oob, e_oob);
            if (e_wen) begin
                chk("mon_addr", rf_wr_addr, m_w.addr);
                chk("mon_data", rf_d_in, m_w.data);
                chk("mon_tlast", rf_tlast_in, m_w.tlast);
            end
            chk("mon_valid", rf_valid, m_valid);
            chk("mon_cnt", wr_count, m_cnt);

            nv = m_valid;
            for (int k = 0; k < D; k++) begin
                if (e_wen && int'(m_w.addr) == k) nv[k] = 1'b1;
                else if (clr_en && int'(clr_addr) == k) nv[k] = 1'b0;
                else if (flush) nv[k] = 1'b0;
            end
            m_valid = nv;
            if (e_wen && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;

            g = -1;
            if (!hold) begin
                for (int o = 0; o < N; o++) begin
                    mi = (m_ptr + o) % N;
                    if (g < 0 && req_valid[mi]) g = mi;
                end
            end
            e_rdy = '0;
            if (g >= 0) e_rdy[g] = 1'b1;
            chk("mon_ready", req_ready, e_rdy);
            if (g >= 0) begin
                m_w.addr  = req_addr[g*AW +: AW];
                m_w.data  = req_data[g*PW +: PW];
                m_w.tlast = req_tlast[g*TW +: TW];
                m_w.oob   = (int'(m_w.addr) >= D);
                exp_q.push_back(m_w);
                gl.push_back(g);
                m_ptr = (g + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [PW-1:0] d, input logic [TW-1:0] t);
        req_addr[i*AW +: AW]  = a;
        req_data[i*PW +: PW]  = d;
        req_tlast[i*TW +: TW] = t;
    endtask

    logic [PW-1:0] pat_a5;

    initial begin
        // Reset state, with requests presented during reset
        req_valid = 3'b111;
        step();
        step();
        chk("rst_rf_wen", rf_wen, '0);
        chk("rst_rf_wr_addr", rf_wr_addr, '0);
        chk("rst_rf_d_in", rf_d_in, '0);
        chk("rst_rf_tlast", rf_tlast_in, '0);
        chk("rst_err_oob", err_oob, '0);
        chk("rst_wr_count", wr_count, '0);
        chk("rst_req_ready", req_ready, '0);
        req_valid = '0;
        rst_n = 1'b1;
        step();

        // All requesters valid for 6 cycles: 0,1,2,0,1,2
        for (int i = 0; i < N; i++) set_req(i, AW'(i), {16{32'h1000_0000 + 32'(i)}}, TW'(i + 1));
        gl.delete();
        req_valid = 3'b111;
        repeat (6) step();
        req_valid = '0;
        step();
        step();
        chk("t1_ngrants", gl.size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("t1_gnt%0d", k), gl[k], k % 3);
        chk("t1_wr_count", wr_count, 6);

        // Set rr_ptr=1 via one grant to 0, then 3'b101: grants 2,0,2
        gl.delete();
        req_valid = 3'b001;
        step();
        req_valid = 3'b101;
        repeat (3) step();
        req_valid = '0;
        step();
        step();
        chk("t2_ngrants", gl.size(), 4);
        chk("t2_gnt1", gl[1], 2);
        chk("t2_gnt2", gl[2], 0);
        chk("t2_gnt3", gl[3], 2);

        // Write addr 5, check issue and scoreboard
        flush = 1'b1;
        step();
        flush = 1'b0;
        pat_a5 = {64{8'hA5}};
        set_req(0, 4'd5, pat_a5, 16'h8000);
        req_valid = 3'b001;
        #1;
        chk("t3_ready", req_ready, 3'b001);
        step();
        req_valid = '0;
        chk("t3_wen", rf_wen, 1'b1);
        chk("t3_addr", rf_wr_addr, 4'd5);
        chk("t3_data", rf_d_in, pat_a5);
        chk("t3_tlast", rf_tlast_in, 16'h8000);
        chk("t3_valid5_pre", rf_valid[5], 1'b0);
        step();
        chk("t3_valid5", rf_valid[5], 1'b1);

        // Write addr 3 coincident with clear(3) and flush: only bit 3 survives
        set_req(0, 4'd3, {16{32'hDEAD_0003}}, 16'h0001);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        clr_en = 1'b1;
        clr_addr = 4'd3;
        flush = 1'b1;
        chk("t4_wen", rf_wen, 1'b1);
        step();
        clr_en = 1'b0;
        flush = 1'b0;
        chk("t4_valid_set", rf_valid, 12'h008);
        clr_en = 1'b1;
        step();
        clr_en = 1'b0;
        chk("t4_valid_clr", rf_valid, 12'h000);

        // Out-of-range address 14
        set_req(0, 4'd14, {16{32'hBAD0_000E}}, 16'h00FF);
        req_valid = 3'b001;
        #1;
        chk("t5_ready", req_ready, 3'b001);
        step();
        req_valid = '0;
        chk("t5_wen", rf_wen, 1'b0);
        chk("t5_err", err_oob, 1'b1);
        step();
        chk("t5_err_clr", err_oob, 1'b0);
        chk("t5_wr_count", wr_count, 12);
        chk("t5_valid", rf_valid, 12'h000);

        // Hold for 4 cycles; pointer stays at 1 so requester 1 wins on release
        for (int i = 0; i < N; i++) set_req(i, 4'd7, {16{32'h7700_0000 + 32'(i)}}, 16'h0700);
        gl.delete();
        hold = 1'b1;
        req_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("t6_hold_ready%0d", c), req_ready, 3'b000);
            step();
        end
        hold = 1'b0;
        #1;
        chk("t6_release_ready", req_ready, 3'b010);
        step();
        req_valid = '0;
        chk("t6_wen", rf_wen, 1'b1);
        chk("t6_addr", rf_wr_addr, 4'd7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wen_async", rf_wen, 1'b0);
        step();
        chk("t6_rst_valid", rf_valid, 12'h000);
        chk("t6_rst_count", wr_count, 0);
        rst_n = 1'b1;
        step();
        step();
        chk("t6_no_reissue", rf_wen, 1'b0);
        chk("t6_ngrants", gl.size(), 1);
        chk("t6_gnt", gl[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
